// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and helpers for the stream_demux block
package stream_demux_pkg;

  // Width and ceiling of the out-of-range drop counter.
  localparam int DROP_CNT_W = 16;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  localparam drop_cnt_t DROP_CNT_MAX = '1;

  // Saturating increment: the counter parks at its ceiling instead of wrapping.
  function automatic drop_cnt_t drop_cnt_inc(input drop_cnt_t cnt);
    return (cnt == DROP_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/demux_decode.sv
// rtl/demux_decode.sv - SEL_W to NCH one-hot decoder with enable and out-of-range flag
module demux_decode #(
  parameter int NCH   = 8,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NCH-1:0]   onehot_o,
  output logic             oor_o
);

  // A select can only be out of range when NCH is not a power of two.
  generate
    if ((1 << SEL_W) > NCH) begin : g_oor
      assign oor_o = (32'(sel_i) >= NCH);
    end else begin : g_no_oor
      assign oor_o = 1'b0;
    end
  endgenerate

  // One output line per channel, each the AND of enable and a select match.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NCH; i++) begin
      onehot_o[i] = en_i && !oor_o && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-NCH stream demux; broadcast under STREAM_DEMUX_BCAST_EN
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 8,
  parameter int SEL_W  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       drop_cnt
);

  typedef logic [NCH-1:0] pend_t;

  pend_t             pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  drop_cnt_t         drop_q, drop_d;

  pend_t             dec_onehot;
  logic              dec_oor;
  logic              bcast_beat;
  logic              accept;

  demux_decode #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel_i    (in_sel),
    .en_i     (1'b1),
    .onehot_o (dec_onehot),
    .oor_o    (dec_oor)
  );

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast_beat = in_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast_beat   = 1'b0;
`endif

  // Ready when no pending channel is left holding the beat after this cycle,
  // so a final drain and a new accept can share one edge.
  assign in_ready = ((pend_q & ~out_ready) == '0);
  assign accept   = in_valid && in_ready;

  // Drain each channel independently, then overlay a freshly accepted beat.
  always_comb begin
    pend_d = pend_q & ~out_ready;
    data_d = data_q;
    drop_d = drop_q;
    if (accept) begin
      data_d = in_data;
      if (bcast_beat) begin
        pend_d = '1;
      end else begin
        // An out-of-range select decodes to no channel and is counted.
        pend_d = dec_onehot;
        if (dec_oor) begin
          drop_d = drop_cnt_inc(drop_q);
        end
      end
    end
  end

  // Single holding stage; reset discards any beat still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard testbench for stream_demux (NCH=8 and NCH=5 instances)
module tb_stream_demux;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in5_valid = 1'b0;
  logic [2:0] in_sel = '0;
  logic [7:0] in_data = '0;
  logic       in_bcast = 1'b0;
  logic [7:0] out_ready = '0;
  logic [4:0] out5_ready = '0;

  logic        in_ready8, in_ready5;
  logic [7:0]  out_valid8, out_data8, out_data5;
  logic [4:0]  out_valid5;
  logic [15:0] drop8, drop5;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .NCH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .drop_cnt(drop8)
  );

  stream_demux #(.DATA_W(8), .NCH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(in_ready5),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid5), .out_ready(out5_ready), .out_data(out_data5),
    .drop_cnt(drop5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed channel handshake pops and compares the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        if (out_valid8[i] && out_ready[i]) begin
          if (q8.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb8_unexpected: got ch %0d data %0h expected no delivery", i, out_data8);
          end else begin
            e8 = q8.pop_front();
            chk("sb8_ch", i, e8.ch);
            chk("sb8_data", {24'd0, out_data8}, {24'd0, e8.data});
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (out_valid5[i] && out5_ready[i]) begin
          if (q5.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb5_unexpected: got ch %0d data %0h expected no delivery", i, out_data5);
          end else begin
            e5 = q5.pop_front();
            chk("sb5_ch", i, e5.ch);
            chk("sb5_data", {24'd0, out_data5}, {24'd0, e5.data});
          end
        end
      end
    end
  end

  initial begin
    // Reset with all consumers stalled.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {24'd0, out_valid8}, 32'h0);
    chk("rst_data", {24'd0, out_data8}, 32'h0);
    chk("rst_drop", {16'd0, drop8}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready8}, 32'h1);
    step();

    // Unicast stream, one beat per cycle, one cycle latency.
    out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_sel   = 3'(k);
      in_data  = 8'(8'hA0 + k);
      q8.push_back('{ch: k, data: 8'(8'hA0 + k)});
      @(negedge clk);
      chk("uni_in_ready", {31'd0, in_ready8}, 32'h1);
      if (k > 0) chk("uni_valid", {24'd0, out_valid8}, 32'h1 << (k - 1));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("uni_last_valid", {24'd0, out_valid8}, 32'h80);
    chk("uni_last_data", {24'd0, out_data8}, 32'hA7);
    step();
    @(negedge clk);
    chk("uni_idle", {24'd0, out_valid8}, 32'h0);
    step();

    // Backpressure on channel 3; the follow-up beat loads on the drain edge.
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_sel    = 3'd3;
    in_data   = 8'h5C;
    q8.push_back('{ch: 3, data: 8'h5C});
    @(negedge clk);
    chk("bp_accept", {31'd0, in_ready8}, 32'h1);
    step();
    in_sel  = 3'd1;
    in_data = 8'h11;
    q8.push_back('{ch: 1, data: 8'h11});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", {24'd0, out_valid8}, 32'h08);
      chk("bp_hold_data", {24'd0, out_data8}, 32'h5C);
      chk("bp_hold_ready", {31'd0, in_ready8}, 32'h0);
      step();
    end
    out_ready = 8'hFF;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready8}, 32'h1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {24'd0, out_valid8}, 32'h02);
    chk("bp_next_data", {24'd0, out_data8}, 32'h11);
    step();
    @(negedge clk);
    chk("bp_idle", {24'd0, out_valid8}, 32'h0);
    step();

    // Broadcast request.
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_bcast  = 1'b1;
    in_sel    = 3'd2;
    in_data   = 8'h3F;
    @(negedge clk);
    chk("bc_accept", {31'd0, in_ready8}, 32'h1);
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
`ifdef STREAM_DEMUX_BCAST_EN
    @(negedge clk);
    chk("bc_all_valid", {24'd0, out_valid8}, 32'hFF);
    for (int j = 0; j < 8; j++) begin
      out_ready = 8'((1 << (j + 1)) - 1);
      q8.push_back('{ch: j, data: 8'h3F});
      @(negedge clk);
      chk("bc_pending", {24'd0, out_valid8}, {24'd0, 8'(8'hFF << j)});
      chk("bc_in_ready", {31'd0, in_ready8}, (j == 7) ? 32'h1 : 32'h0);
      step();
    end
`else
    @(negedge clk);
    chk("bc_ignored_valid", {24'd0, out_valid8}, 32'h04);
    out_ready = 8'hFF;
    q8.push_back('{ch: 2, data: 8'h3F});
    @(negedge clk);
    chk("bc_ignored_ready", {31'd0, in_ready8}, 32'h1);
    step();
`endif
    @(negedge clk);
    chk("bc_idle", {24'd0, out_valid8}, 32'h0);
    step();

    // Out-of-range selects on the NCH=5 instance, then saturation.
    out5_ready = 5'h1F;
    in5_valid  = 1'b1;
    in_sel     = 3'd6;
    in_data    = 8'h66;
    @(negedge clk);
    chk("oor_accept", {31'd0, in_ready5}, 32'h1);
    step();
    in_sel  = 3'd4;
    in_data = 8'h44;
    q5.push_back('{ch: 4, data: 8'h44});
    @(negedge clk);
    chk("oor_no_valid", {27'd0, out_valid5}, 32'h0);
    chk("oor_drop1", {16'd0, drop5}, 32'h1);
    step();
    in_sel  = 3'd5;
    in_data = 8'h55;
    @(negedge clk);
    chk("edge_ch4_valid", {27'd0, out_valid5}, 32'h10);
    chk("edge_ch4_data", {24'd0, out_data5}, 32'h44);
    step();
    in_sel = 3'd7;
    @(negedge clk);
    chk("oor_drop2", {16'd0, drop5}, 32'h2);
    chk("oor5_no_valid", {27'd0, out_valid5}, 32'h0);
    repeat (65540) step();
    in5_valid = 1'b0;
    @(negedge clk);
    chk("oor_saturate", {16'd0, drop5}, 32'hFFFF);
    chk("drop8_zero", {16'd0, drop8}, 32'h0);
    step();

    // Reset while a beat is held; it must never be delivered.
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_sel    = 3'd2;
    in_data   = 8'h77;
    @(negedge clk);
    chk("rh_accept", {31'd0, in_ready8}, 32'h1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rh_hold", {24'd0, out_valid8}, 32'h04);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rh_valid_cleared", {24'd0, out_valid8}, 32'h0);
    chk("rh_data_cleared", {24'd0, out_data8}, 32'h0);
    chk("rh_drop_cleared", {16'd0, drop5}, 32'h0);
    rst = 1'b0;
    out_ready = 8'hFF;
    step();
    step();
    @(negedge clk);
    chk("rh_never_delivered", {24'd0, out_valid8}, 32'h0);

    chk("sb8_drained", q8.size(), 32'h0);
    chk("sb5_drained", q5.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
